// File: rtl/sha256_digest_uart_tx.sv
// Streams a latched 256-bit SHA-256 digest over an 8N1 UART as 64 lowercase
// hex characters followed by CR LF, with back-to-back frames and no idle gaps.
module sha256_digest_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] digest_in,
    input  logic         digest_valid,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned NUM_BYTES = 66;
    localparam logic [6:0]  LAST_BYTE = 7'(NUM_BYTES - 1);
    localparam logic [6:0]  CR_BYTE   = 7'(NUM_BYTES - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [2:0]          bit_cnt, bit_nxt;
    logic [6:0]          byte_idx, byte_nxt;
    logic [255:0]        digest_reg, digest_nxt;
    logic                tx_nxt, busy_nxt, done_nxt;

    logic                bit_end_c;
    logic                accept_c;
    logic [5:0]          nib_sel_c;
    logic [3:0]          nib_c;
    logic [7:0]          char_c;

    assign bit_end_c = (tick_cnt == TICK_W'(BIT_TICKS - 1));
    // A request landing on the done cycle is dropped; IDLE accepts from the next cycle.
    assign accept_c  = (state == IDLE) && digest_valid && !done;

    // Character for the current byte index: hex nibble MSB first, then CR, LF.
    assign nib_sel_c = 6'(7'd63 - byte_idx);
    assign nib_c     = digest_reg[{nib_sel_c, 2'b00} +: 4];
    always_comb begin
        if (byte_idx == CR_BYTE)
            char_c = 8'h0D;
        else if (byte_idx == LAST_BYTE)
            char_c = 8'h0A;
        else if (nib_c < 4'd10)
            char_c = 8'h30 + {4'h0, nib_c};
        else
            char_c = 8'h57 + {4'h0, nib_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept_c) state_nxt = START;
            START: if (bit_end_c) state_nxt = DATA;
            DATA:  if (bit_end_c && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end_c) state_nxt = (byte_idx == LAST_BYTE) ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and the bit/byte/tick counters.
    always_comb begin
        tick_nxt   = bit_end_c ? '0 : TICK_W'(tick_cnt + 1'b1);
        bit_nxt    = bit_cnt;
        byte_nxt   = byte_idx;
        digest_nxt = digest_reg;
        tx_nxt     = tx;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                tick_nxt = '0;
                if (accept_c) begin
                    digest_nxt = digest_in;
                    byte_nxt   = '0;
                    bit_nxt    = '0;
                    tx_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    bit_nxt = '0;
                    tx_nxt  = char_c[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_cnt == 3'd7) begin
                        tx_nxt = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        tx_nxt  = char_c[bit_cnt + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (byte_idx == LAST_BYTE) begin
                        byte_nxt = '0;
                        tx_nxt   = 1'b1;
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        byte_nxt = byte_idx + 7'd1;
                        tx_nxt   = 1'b0;
                    end
                end
            end
            default: tick_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            digest_reg <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            byte_idx   <= byte_nxt;
            digest_reg <= digest_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: doc/sha256_digest_uart_tx.md
SHA256_DIGEST_UART_TX -- requirements
Module: sha256_digest_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate.
REQ-003 SHALL derive BIT_TICKS = CLK_FREQ / BAUD_RATE (integer division), the number of clock cycles per UART bit.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port digest_in  input  256  SHA-256 digest; bit 255 is the MSB of the first hash byte.
REQ-007 SHALL have port digest_valid  input  1  one-cycle request to transmit digest_in.
REQ-008 SHALL have port tx  output  1  UART TX line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-011 SHALL sample digest_valid only in IDLE; digest_in SHALL be latched into an internal register on the same edge.
REQ-012 SHALL ignore digest_valid while busy=1; the latched digest SHALL NOT change during a transfer.
REQ-013 SHALL transmit 66 bytes per transfer: 64 lowercase ASCII hex characters, then 0x0D, then 0x0A.
REQ-014 Hex characters SHALL be sent in MSB-nibble-first order, starting with digest[255:252] and ending with digest[3:0].
REQ-015 Nibble encoding SHALL be 0-9 -> 0x30+n and 10-15 -> 0x61+(n-10).
REQ-016 Each byte SHALL be framed as: start bit 0, then 8 data bits LSB first, then one stop bit 1.
REQ-017 Every bit SHALL hold tx for exactly BIT_TICKS clock cycles, timed by a bit counter that restarts at each bit boundary.
REQ-018 The start bit of byte k+1 SHALL begin on the cycle immediately after the stop bit of byte k ends, with no idle gap.
REQ-019 State machine SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on digest_valid.
- START -> DATA after BIT_TICKS cycles.
- DATA -> STOP after 8 bits.
- STOP -> START if bytes remain; STOP -> IDLE after byte 66.
REQ-020 tx and busy SHALL be registered, and both SHALL change on the clock edge after digest_valid is sampled (tx falls to 0, busy rises to 1).
REQ-021 On the final STOP -> IDLE transition, done SHALL pulse high for exactly one cycle, busy SHALL fall on that same cycle, and tx SHALL remain 1.
REQ-022 Total transfer duration, from busy rising to busy falling, SHALL be 660*BIT_TICKS cycles.
REQ-023 A byte index counter (0..65) SHALL select each character; it SHALL reset to 0 at the start of every transfer.
REQ-024 digest_valid asserted on the same cycle that done pulses SHALL be ignored; a new request is accepted from the following cycle onward.

Reset
REQ-025 While rst_n=0, outputs SHALL be: tx=1, busy=0, done=0; state=IDLE, all counters=0, digest register=0.
REQ-026 Reset asserted mid-transfer SHALL immediately abandon the transfer, force tx high asynchronously, and produce no done pulse.
REQ-027 After rst_n deasserts, the block SHALL accept digest_valid from the first rising clock edge onward.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, BIT_TICKS=10)
REQ-028 SHALL cover: digest = SHA-256("abc") (ba7816bf...f20015ad), one digest_valid pulse -> UART decoder reads "ba7816bf...f20015ad\r\n" (66 bytes); busy high for 6600 cycles; exactly one done pulse.
REQ-029 SHALL cover: digest = all 0x00 -> 64 bytes of 0x30 then 0x0D 0x0A; first frame is tx low 10 cycles, then data bits 0,0,0,0,1,1,0,0.
REQ-030 SHALL cover: digest = all 0xFF -> 64 bytes of 0x66 then 0x0D 0x0A; no idle cycles between consecutive frames.
REQ-031 SHALL cover: second digest_valid with a different digest, pulsed 1000 cycles into a transfer -> output still matches the first digest; no second transfer starts.
REQ-032 SHALL cover: rst_n pulsed low at cycle 3000 of a transfer -> tx=1 and busy=0 immediately, no done pulse; a new request after reset transmits correctly.
REQ-033 SHALL cover: two back-to-back transfers, with digest_valid pulsed on the cycle after done -> second transfer starts with no extra delay, and both output strings are correct.
